// File: rtl/gcd_pkg.sv
// Purpose: shared types and constants for the subtractive GCD control/datapath pair.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package gcd_pkg;

  // Operand width shared by the controller, datapath and bench.
  localparam int GCD_W = 4;

  // Worst-case subtraction count for GCD_W-bit operands: gcd(2**W-1, 1).
  localparam int GCD_MAX_ITER = 2**GCD_W - 2;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CMP,
    DONE,
    ERR
  } gcd_state_t;

endpackage

// File: rtl/gcd_ctrl_if.sv
// Purpose: request handshake plus datapath control/flag bundle between system logic, gcd_ctrl and gcd_datapath.
// Latency: n/a (wires only).
// Backpressure: start is only taken while ready is high; no queuing.
// Ports: start/A/B/eq_flag/bigger toward the controller (slave), strobes and status back out (master side drives inputs).
interface gcd_ctrl_if
  import gcd_pkg::*;
#(
  parameter int W        = GCD_W,
  parameter int MAX_ITER = GCD_MAX_ITER,
  parameter int CW       = $clog2(MAX_ITER + 1)
);

  // Request side
  logic          start;
  logic [W-1:0]  A;
  logic [W-1:0]  B;
  logic          ready;
  logic          busy;
  logic          res_valid;
  logic          err;
  logic [CW-1:0] iter_count;

  // Datapath side
  logic          eq_flag;
  logic          bigger;
  logic          rst_dp;
  logic          A_sel;
  logic          B_sel;
  logic          A_load;
  logic          B_load;
  logic          done;

  // Controller end of the bundle.
  modport slave (
    input  start, A, B, eq_flag, bigger,
    output ready, busy, res_valid, err, iter_count,
    output rst_dp, A_sel, B_sel, A_load, B_load, done
  );

  // Requester/datapath end of the bundle.
  modport master (
    output start, A, B, eq_flag, bigger,
    input  ready, busy, res_valid, err, iter_count,
    input  rst_dp, A_sel, B_sel, A_load, B_load, done
  );

endinterface

// File: rtl/gcd_iter_cnt.sv
// Purpose: subtraction counter for one GCD job, with clear, increment and terminal count.
// Latency: count updates one cycle after clr/inc.
// Backpressure: none; inc is ignored once count reaches MAX_ITER (saturating).
// Ports: clk, rst (sync, active-high), clr, inc in; count (CW bits), tc (count==MAX_ITER) out.
module gcd_iter_cnt #(
  parameter int MAX_ITER = 14,
  parameter int CW       = $clog2(MAX_ITER + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] count,
  output logic          tc
);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  assign tc    = (count_q == CW'(MAX_ITER));
  assign count = count_q;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && !tc) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/gcd_ctrl.sv
// Purpose: control FSM for the subtractive GCD datapath; rejects zero operands and times out runaway jobs.
// Latency: 3+k cycles from accepted start to res_valid (k = subtractions); 1 cycle for a zero operand.
// Backpressure: ready only in IDLE; start elsewhere is dropped, never queued.
// Ports: clk, rst (sync, active-high); bus (gcd_ctrl_if.slave) carrying start/A/B, flags, strobes and status.
module gcd_ctrl
  import gcd_pkg::*;
#(
  parameter int W        = GCD_W,
  parameter int MAX_ITER = GCD_MAX_ITER
) (
  input  logic       clk,
  input  logic       rst,
  gcd_ctrl_if.slave  bus
);

  localparam int          CW   = $clog2(MAX_ITER + 1);
  localparam logic [W-1:0] ZERO = '0;

  gcd_state_t state_q;
  gcd_state_t state_d;

  logic cnt_clr;
  logic cnt_inc;
  logic cnt_tc;

  logic a_sel;
  logic b_sel;
  logic a_load;
  logic b_load;
  logic done;

  gcd_iter_cnt #(
    .MAX_ITER (MAX_ITER),
    .CW       (CW)
  ) u_iter_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .count (bus.iter_count),
    .tc    (cnt_tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    a_sel   = 1'b0;
    b_sel   = 1'b0;
    a_load  = 1'b0;
    b_load  = 1'b0;
    done    = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          // A zero operand would make the subtraction loop spin forever.
          if (bus.A == ZERO || bus.B == ZERO) begin
            state_d = ERR;
          end else begin
            state_d = LOAD;
            cnt_clr = 1'b1;
          end
        end
      end

      LOAD: begin
        a_load  = 1'b1;
        b_load  = 1'b1;
        state_d = CMP;
      end

      CMP: begin
        // Equality wins over the watchdog so a job that converges on its
        // last allowed step still completes.
        if (bus.eq_flag) begin
          done    = 1'b1;
          state_d = DONE;
        end else if (cnt_tc) begin
          state_d = ERR;
        end else if (bus.bigger) begin
          a_sel   = 1'b1;
          a_load  = 1'b1;
          cnt_inc = 1'b1;
        end else begin
          b_sel   = 1'b1;
          b_load  = 1'b1;
          cnt_inc = 1'b1;
        end
      end

      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.A_sel     = a_sel;
  assign bus.B_sel     = b_sel;
  assign bus.A_load    = a_load;
  assign bus.B_load    = b_load;
  assign bus.done      = done;
  assign bus.ready     = (state_q == IDLE);
  assign bus.busy      = (state_q == LOAD) || (state_q == CMP);
  assign bus.res_valid = (state_q == DONE) || (state_q == ERR);
  assign bus.err       = (state_q == ERR);
  // ERR clears the datapath so a failed job leaves res at zero.
  assign bus.rst_dp    = rst || (state_q == ERR);

endmodule

// File: doc/gcd_ctrl.md
# gcd_ctrl

Control unit for the subtractive GCD datapath. It accepts an operand pair through a start/ready handshake, sequences the datapath's mux-select and load strobes from the returned `eq_flag`/`bigger` flags, and strobes `done` so the datapath captures the result. It also rejects zero operands, which would never converge, and enforces an iteration watchdog. It sits between the system request logic and `gcd_datapath`, and is the other end of that control/flag interface.

## Interface
- `W`, 4: operand width; must match the datapath.
- `MAX_ITER`, 2**W-2: maximum subtraction steps before timeout (14 for W=4, the worst case gcd(15,1)).
- `CW`, $clog2(MAX_ITER+1): iteration counter width (derived).

- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  request; sampled only in IDLE.
- `A`, `B`  in  W  operands; same bus that feeds the datapath muxes; checked for zero at start.
- `eq_flag`  in  1  from datapath: a==b.
- `bigger`  in  1  from datapath: a>b.
- `rst_dp`  out  1  datapath reset.
- `A_sel`, `B_sel`  out  1  0=load operand, 1=load difference.
- `A_load`, `B_load`  out  1  register load strobes.
- `done`  out  1  loads the datapath result register from a.
- `ready`  out  1  high in IDLE.
- `busy`  out  1  high in LOAD/CMP.
- `res_valid`  out  1  one-cycle pulse; the result or error is final.
- `err`  out  1  one-cycle pulse with `res_valid` on zero operand or timeout.
- `iter_count`  out  CW  subtractions performed in the current/last job.

## Operation
- States: IDLE, LOAD, CMP, DONE, ERR. Strobe outputs are decoded combinationally from state and flags. All unasserted strobes are 0.
- IDLE:
  - `ready`=1.
  - On `start`, if A==0 or B==0: go to ERR.
  - On `start` otherwise: go to LOAD and clear `iter_count`.
- LOAD:
  - A_sel=B_sel=0, A_load=B_load=1.
  - Go to CMP.
- CMP (evaluated every cycle, in priority order):
  1. `eq_flag`: assert `done`, go to DONE.
  2. Else if `iter_count`==MAX_ITER: go to ERR. No load in this cycle.
  3. Else if `bigger`: A_sel=1, A_load=1 (a<=a-b), `iter_count`++, stay in CMP.
  4. Else: B_sel=1, B_load=1 (b<=b-a), `iter_count`++, stay in CMP.
- DONE: `res_valid`=1, then go to IDLE. The datapath `res` is valid from this cycle and holds until the next `done`.
- ERR: `res_valid`=1, `err`=1, `rst_dp`=1 (clears datapath a/b/res), then go to IDLE.
- `rst_dp` = `rst` OR (state==ERR).
- `start` outside IDLE is ignored; no queuing.
- `iter_count` saturates by construction (never exceeds MAX_ITER). It holds its value after the job until the next accepted start.

## Timing
- Reset: state=IDLE, `iter_count`=0, `busy`=0, `res_valid`=0, `err`=0, all strobes 0, `ready`=1 from the cycle after `rst` is sampled.
- `rst_dp` follows `rst` in the same cycle.
- `rst` mid-job aborts without a `res_valid` pulse.
- Accepted `start` at cycle 0:
  - LOAD at cycle 1; operands are in the datapath at cycle 2.
  - CMP at cycles 2..2+k, where k = number of subtractions.
  - `done` at cycle 2+k.
  - `res_valid` at cycle 3+k. Latency is 3+k.
- Zero operand: ERR at cycle 1, `err`/`res_valid` at cycle 1, no datapath loads.
- Timeout: ERR at cycle 3+MAX_ITER.
- `ready` returns at the cycle after `res_valid`. Back-to-back starts are accepted at that cycle.

## Structure
- Shared package `gcd_pkg`:
  - state enum `gcd_state_t`.
  - default `GCD_W`=4.
  - `GCD_MAX_ITER` constant, shared with the datapath and bench.
- One sub-module `gcd_iter_cnt`: CW-bit counter with clear, increment enable, and terminal-count output (`iter_count`==MAX_ITER).
- FSM and output decode live in `gcd_ctrl`.

## Test plan
- A=12, B=8, start at cycle 0 -> subtractions a:12->4, then b:8->4. k=2, `done` at cycle 4, `res_valid` at cycle 5, res=4, `iter_count`=2, `err`=0.
- A=15, B=1 -> k=14, `res_valid` at cycle 17, res=1, no timeout at default MAX_ITER.
- A=7, B=7 -> no subtraction, `done` at cycle 2, `res_valid` at cycle 3, res=7, `iter_count`=0.
- A=0, B=5 -> `err` and `res_valid` at cycle 1, `rst_dp` at cycle 1, no load strobes. Repeat with A=5, B=0 and A=B=0 for the same response.
- MAX_ITER=3, A=15, B=1 -> 3 A-subtractions at cycles 2-4, ERR at cycle 6 with `err`=1, then datapath res=0.
- Mid-job: `rst` at cycle 3 of (12,8) -> IDLE next cycle, no `res_valid`. A `start` during `busy` is ignored. A new `start` on the cycle after `res_valid` completes normally.
